// File: rtl/jtag_bist_dr.sv
// JTAG data-register bank in front of the BIST engine: scan-loaded config/user shadows,
// a cycle-counted BIST run sequencer, and a capturable status word.
module jtag_bist_dr #(
    parameter int unsigned CONF_W    = 13,
    parameter int unsigned USER_W    = 2052,
    parameter int unsigned STAT_W    = 16,
    parameter int unsigned RUN_W     = 16,
    parameter logic [3:0]  IR_CONF   = 4'h2,
    parameter logic [3:0]  IR_USER   = 4'h3,
    parameter logic [3:0]  IR_RUN    = 4'h4,
    parameter logic [3:0]  IR_STATUS = 4'h5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [3:0]        IR,
    input  logic              CAPTURE_DR,
    input  logic              SHIFT_DR,
    input  logic              UPDATE_DR,
    input  logic              TDI,
    output logic              TDO,
    input  logic [STAT_W-1:0] BIST_STATUS_REG,
    output logic [CONF_W-1:0] BIST_CONF_REG,
    output logic [USER_W-1:0] BIST_USER_TEST,
    output logic              ENABLE,
    output logic              BIST_BUSY,
    output logic              BIST_DONE
);

    localparam int unsigned STS_W = STAT_W + 2;

    typedef enum logic [1:0] {StIdle, StRun, StSettle, StDone} state_e;

    state_e            state_q, state_d;
    logic [CONF_W-1:0] conf_sr_q, conf_sr_d, conf_q, conf_d;
    logic [USER_W-1:0] user_sr_q, user_sr_d, user_q, user_d;
    logic [RUN_W-1:0]  run_sr_q, run_sr_d, cnt_q, cnt_d;
    logic [STS_W-1:0]  sts_sr_q, sts_sr_d;
    logic [STAT_W-1:0] hold_q, hold_d;
    logic              byp_q, byp_d, tdo_q, tdo_d;
    logic              sel_conf, sel_user, sel_run, sel_sts;
    logic              can_load, do_update;

    assign sel_conf  = (IR == IR_CONF);
    assign sel_user  = (IR == IR_USER);
    assign sel_run   = (IR == IR_RUN);
    assign sel_sts   = (IR == IR_STATUS);
    assign can_load  = (state_q == StIdle) || (state_q == StDone);
    assign do_update = UPDATE_DR && !CAPTURE_DR && !SHIFT_DR;

    assign ENABLE         = (state_q == StRun);
    assign BIST_BUSY      = (state_q == StRun) || (state_q == StSettle);
    assign BIST_DONE      = (state_q == StDone);
    assign BIST_CONF_REG  = conf_q;
    assign BIST_USER_TEST = user_q;
    assign TDO            = tdo_q;

    always_comb begin
        conf_sr_d = conf_sr_q;
        user_sr_d = user_sr_q;
        run_sr_d  = run_sr_q;
        sts_sr_d  = sts_sr_q;
        byp_d     = byp_q;
        if (CAPTURE_DR) begin
            if (sel_conf)      conf_sr_d = conf_q;
            else if (sel_user) user_sr_d = user_q;
            else if (sel_run)  run_sr_d  = cnt_q;
            else if (sel_sts)  sts_sr_d  = {BIST_BUSY, BIST_DONE, hold_q};
            else               byp_d     = 1'b0;
        end else if (SHIFT_DR) begin
            if (sel_conf)      conf_sr_d = {TDI, conf_sr_q[CONF_W-1:1]};
            else if (sel_user) user_sr_d = {TDI, user_sr_q[USER_W-1:1]};
            else if (sel_run)  run_sr_d  = {TDI, run_sr_q[RUN_W-1:1]};
            else if (sel_sts)  sts_sr_d  = {TDI, sts_sr_q[STS_W-1:1]};
            else               byp_d     = TDI;
        end
        // TDO is registered from the next LSB so it never sees TDI combinationally.
        tdo_d = byp_d;
        if (sel_conf)      tdo_d = conf_sr_d[0];
        else if (sel_user) tdo_d = user_sr_d[0];
        else if (sel_run)  tdo_d = run_sr_d[0];
        else if (sel_sts)  tdo_d = sts_sr_d[0];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        conf_d  = conf_q;
        user_d  = user_q;
        case (state_q)
            StRun: begin
                cnt_d = cnt_q - RUN_W'(1);
                if (cnt_q == RUN_W'(1)) state_d = StSettle;
            end
            StSettle: begin
                hold_d  = BIST_STATUS_REG;
                state_d = StDone;
            end
            default: ;
        endcase
        if (do_update) begin
            if (sel_conf && can_load) conf_d = conf_sr_q;
            if (sel_user && can_load) user_d = user_sr_q;
            if (sel_run) begin
                if (can_load && (run_sr_q != '0)) begin
                    state_d = StRun;
                    cnt_d   = run_sr_q;
                end else if ((state_q == StRun) && (run_sr_q == '0)) begin
                    // Abort: drop back to idle without latching a result.
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StIdle;
            conf_sr_q <= '0;
            user_sr_q <= '0;
            run_sr_q  <= '0;
            sts_sr_q  <= '0;
            byp_q     <= 1'b0;
            tdo_q     <= 1'b0;
            conf_q    <= '0;
            user_q    <= '0;
            cnt_q     <= '0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            conf_sr_q <= conf_sr_d;
            user_sr_q <= user_sr_d;
            run_sr_q  <= run_sr_d;
            sts_sr_q  <= sts_sr_d;
            byp_q     <= byp_d;
            tdo_q     <= tdo_d;
            conf_q    <= conf_d;
            user_q    <= user_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
        end
    end

endmodule

// File: tb/tb_jtag_bist_dr.sv
// Scoreboard bench for jtag_bist_dr: scans queue expected TDO words and run lengths,
// a monitor pops and compares them as the DUT produces them.
module tb_jtag_bist_dr;

    localparam int CONF_W = 13;
    localparam int USER_W = 2052;
    localparam int STAT_W = 16;
    localparam int RUN_W  = 16;
    localparam logic [3:0] IR_CONF   = 4'h2;
    localparam logic [3:0] IR_USER   = 4'h3;
    localparam logic [3:0] IR_RUN    = 4'h4;
    localparam logic [3:0] IR_STATUS = 4'h5;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic [3:0]        IR = 4'h0;
    logic              CAPTURE_DR = 1'b0;
    logic              SHIFT_DR = 1'b0;
    logic              UPDATE_DR = 1'b0;
    logic              TDI = 1'b0;
    logic              TDO;
    logic [STAT_W-1:0] BIST_STATUS_REG = '0;
    logic [CONF_W-1:0] BIST_CONF_REG;
    logic [USER_W-1:0] BIST_USER_TEST;
    logic              ENABLE, BIST_BUSY, BIST_DONE;

    jtag_bist_dr dut (
        .CLK(CLK), .RST(RST), .IR(IR), .CAPTURE_DR(CAPTURE_DR), .SHIFT_DR(SHIFT_DR),
        .UPDATE_DR(UPDATE_DR), .TDI(TDI), .TDO(TDO), .BIST_STATUS_REG(BIST_STATUS_REG),
        .BIST_CONF_REG(BIST_CONF_REG), .BIST_USER_TEST(BIST_USER_TEST), .ENABLE(ENABLE),
        .BIST_BUSY(BIST_BUSY), .BIST_DONE(BIST_DONE)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc++;

    typedef struct {
        logic [USER_W-1:0] val;
        int                len;
        string             name;
    } word_t;

    word_t exp_tdo[$];
    int    exp_en[$];
    int    exp_busy[$];
    int    checks = 0;
    int    errors = 0;

    // Reference model state
    logic [CONF_W-1:0] conf_m = '0;
    logic [USER_W-1:0] user_m = '0;
    logic [STAT_W-1:0] hold_m = '0;
    logic [STAT_W-1:0] st_m = '0;
    logic              done_m = 1'b0;
    logic              running = 1'b0;
    int                run_ts = 0;
    int                run_n = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic check_wide(input string name, input logic [USER_W-1:0] act,
                              input logic [USER_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got low64 0x%0h, expected low64 0x%0h (%0d bits differ)",
                     name, act[63:0], exp[63:0], $countones(act ^ exp));
        end
    endtask

    function automatic logic [USER_W-1:0] ext(input logic [63:0] v);
        logic [USER_W-1:0] r;
        r = '0;
        r[63:0] = v;
        return r;
    endfunction

    function automatic logic [USER_W-1:0] sts_word(input logic busy, input logic done);
        logic [USER_W-1:0] r;
        r = '0;
        r[STAT_W+1:0] = {busy, done, hold_m};
        return r;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Capture, shift len bits LSB-first, optionally update; queue the expected TDO word.
    task automatic scan(input logic [3:0] ir, input int len, input logic [USER_W-1:0] din,
                        input logic upd, input logic [USER_W-1:0] exp_out, input string name);
        word_t w;
        logic [USER_W-1:0] e;
        e = exp_out;
        IR = ir;
        tick();
        CAPTURE_DR = 1'b1;
        tick();
        CAPTURE_DR = 1'b0;
        // Remaining run count includes the enable cycle just before the capture edge.
        if (ir == IR_RUN && running) e = ext(64'(run_n - (cyc - run_ts - 1)));
        for (int i = len; i < USER_W; i++) e[i] = 1'b0;
        w.val = e;
        w.len = len;
        w.name = name;
        exp_tdo.push_back(w);
        for (int i = 0; i < len; i++) begin
            SHIFT_DR = 1'b1;
            TDI = din[i];
            tick();
        end
        SHIFT_DR = 1'b0;
        TDI = 1'b0;
        if (upd) begin
            UPDATE_DR = 1'b1;
            tick();
            UPDATE_DR = 1'b0;
        end
    endtask

    task automatic pulse_update(input logic [3:0] ir);
        IR = ir;
        UPDATE_DR = 1'b1;
        tick();
        UPDATE_DR = 1'b0;
    endtask

    task automatic start_run(input int n, input logic [STAT_W-1:0] st, input logic normal);
        BIST_STATUS_REG = st;
        scan(IR_RUN, RUN_W, ext(64'(n)), 1'b1, ext(64'(0)), "run_capture");
        run_ts = cyc;
        run_n = n;
        running = 1'b1;
        done_m = 1'b0;
        st_m = st;
        check_bit("enable_first_cycle", ENABLE, 1'b1);
        if (normal) begin
            exp_en.push_back(n);
            exp_busy.push_back(n + 1);
        end
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (BIST_DONE !== 1'b1 && k < 2000) begin
            tick();
            k++;
        end
        check_bit("run_done", BIST_DONE, 1'b1);
        check_bit("busy_after_done", BIST_BUSY, 1'b0);
        running = 1'b0;
        done_m = 1'b1;
        hold_m = st_m;
    endtask

    // Monitor: assembles shifted TDO words and measures ENABLE / BUSY pulse lengths.
    initial begin : monitor
        logic [USER_W-1:0] acc;
        int n, en_len, busy_len, e;
        word_t w;
        acc = '0;
        n = 0;
        en_len = 0;
        busy_len = 0;
        forever begin
            @(negedge CLK);
            if (SHIFT_DR === 1'b1) begin
                if (n < USER_W) acc[n] = TDO;
                n++;
            end else if (n > 0) begin
                if (exp_tdo.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tdo_unexpected: got %0d-bit word, expected none", n);
                end else begin
                    w = exp_tdo.pop_front();
                    check({w.name, "_len"}, 64'(n), 64'(w.len));
                    check_wide(w.name, acc, w.val);
                end
                acc = '0;
                n = 0;
            end
            if (ENABLE === 1'b1) en_len++;
            else if (en_len > 0) begin
                e = (exp_en.size() > 0) ? exp_en.pop_front() : -1;
                check("enable_length", 64'(en_len), 64'(e));
                en_len = 0;
            end
            if (BIST_BUSY === 1'b1) busy_len++;
            else if (busy_len > 0) begin
                e = (exp_busy.size() > 0) ? exp_busy.pop_front() : -1;
                check("busy_length", 64'(busy_len), 64'(e));
                busy_len = 0;
            end
        end
    end

    initial begin : stimulus
        logic [USER_W-1:0] rv;
        logic [CONF_W-1:0] cv;
        logic [STAT_W-1:0] sv;
        int                n, t;

        // Reset
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        check_bit("rst_enable", ENABLE, 1'b0);
        check_bit("rst_busy", BIST_BUSY, 1'b0);
        check_bit("rst_done", BIST_DONE, 1'b0);
        check_bit("rst_tdo", TDO, 1'b0);
        check("rst_conf", 64'(BIST_CONF_REG), 64'(0));
        check_wide("rst_user", BIST_USER_TEST, '0);
        scan(IR_STATUS, STAT_W + 2, ext(64'($urandom)), 1'b0, sts_word(1'b0, 1'b0), "rst_status");

        // CONF load and read-back
        scan(IR_CONF, CONF_W, ext(64'h1A5), 1'b1, ext(64'(conf_m)), "conf_capture");
        conf_m = 13'h1A5;
        check("conf_shadow", 64'(BIST_CONF_REG), 64'(conf_m));
        scan(IR_CONF, CONF_W, ext(64'($urandom)), 1'b0, ext(64'(conf_m)), "conf_readback");

        // Directed 5-cycle run
        start_run(5, 16'hBEEF, 1'b1);
        wait_done();
        scan(IR_STATUS, STAT_W + 2, ext(64'($urandom)), 1'b0, sts_word(1'b0, 1'b1), "status_beef");
        check_bit("done_after_status", BIST_DONE, 1'b1);

        // N=0 from DONE has no effect
        scan(IR_RUN, RUN_W, ext(64'(0)), 1'b1, ext(64'(0)), "run_zero_capture");
        check_bit("zero_run_enable", ENABLE, 1'b0);
        check_bit("zero_run_done", BIST_DONE, done_m);

        // Shortest run
        start_run(1, 16'h0F0F, 1'b1);
        wait_done();

        // Randomized config / run / status rounds
        for (int r = 0; r < 4; r++) begin
            cv = CONF_W'($urandom);
            scan(IR_CONF, CONF_W, ext(64'(cv)), 1'b1, ext(64'(conf_m)), "conf_rand");
            conf_m = cv;
            check("conf_rand_shadow", 64'(BIST_CONF_REG), 64'(conf_m));
            n = int'($urandom_range(1, 20));
            sv = STAT_W'($urandom);
            start_run(n, sv, 1'b1);
            wait_done();
            scan(IR_STATUS, STAT_W + 2, ext(64'($urandom)), 1'b0, sts_word(1'b0, 1'b1),
                 "status_rand");
        end

        // Random user vector load
        for (int i = 0; i < USER_W; i++) rv[i] = 1'($urandom_range(0, 1));
        scan(IR_USER, USER_W, rv, 1'b1, user_m, "user_capture");
        user_m = rv;
        check_wide("user_shadow", BIST_USER_TEST, user_m);

        // Update lockout during a 100-cycle run
        scan(IR_USER, USER_W, '1, 1'b0, user_m, "user_preload");
        start_run(100, 16'hC0DE, 1'b1);
        repeat (3) tick();
        pulse_update(IR_USER);
        check_wide("user_locked", BIST_USER_TEST, user_m);
        wait_done();
        pulse_update(IR_USER);
        user_m = '1;
        check_wide("user_after_done", BIST_USER_TEST, user_m);

        // Abort
        start_run(50, 16'h1234, 1'b0);
        repeat (10) tick();
        scan(IR_RUN, RUN_W, ext(64'(0)), 1'b1, ext(64'(0)), "run_remaining");
        t = cyc;
        running = 1'b0;
        exp_en.push_back(t - run_ts);
        exp_busy.push_back(t - run_ts);
        check_bit("abort_enable", ENABLE, 1'b0);
        check_bit("abort_busy", BIST_BUSY, 1'b0);
        check_bit("abort_done", BIST_DONE, 1'b0);
        scan(IR_STATUS, STAT_W + 2, ext(64'($urandom)), 1'b0, sts_word(1'b0, 1'b0),
             "status_abort");

        // Bypass: 1011 LSB-first then a trailing 0, TDO lags by one bit
        scan(4'hF, 5, ext(64'b01101), 1'b0, ext(64'b11010), "bypass_fixed");
        rv = ext(64'($urandom));
        scan(4'hF, 16, rv, 1'b0, ext({rv[62:0], 1'b0}), "bypass_rand");

        // Capture wins over a simultaneous update
        cv = ~conf_m;
        scan(IR_CONF, CONF_W, ext(64'(cv)), 1'b0, ext(64'(conf_m)), "conf_prio_load");
        CAPTURE_DR = 1'b1;
        UPDATE_DR = 1'b1;
        tick();
        CAPTURE_DR = 1'b0;
        UPDATE_DR = 1'b0;
        check("prio_shadow", 64'(BIST_CONF_REG), 64'(conf_m));
        pulse_update(IR_CONF);
        check("prio_recaptured", 64'(BIST_CONF_REG), 64'(conf_m));

        // Reset in the middle of a run
        start_run(30, 16'h5A5A, 1'b0);
        repeat (5) tick();
        RST = 1'b1;
        tick();
        t = cyc;
        RST = 1'b0;
        running = 1'b0;
        exp_en.push_back(t - run_ts);
        exp_busy.push_back(t - run_ts);
        conf_m = '0;
        user_m = '0;
        hold_m = '0;
        done_m = 1'b0;
        check_bit("midrst_enable", ENABLE, 1'b0);
        check_bit("midrst_busy", BIST_BUSY, 1'b0);
        check_bit("midrst_done", BIST_DONE, 1'b0);
        check_bit("midrst_tdo", TDO, 1'b0);
        check("midrst_conf", 64'(BIST_CONF_REG), 64'(conf_m));
        check_wide("midrst_user", BIST_USER_TEST, user_m);
        scan(IR_STATUS, STAT_W + 2, ext(64'($urandom)), 1'b0, sts_word(1'b0, 1'b0),
             "status_midrst");

        repeat (4) tick();
        check("tdo_queue_drained", 64'(exp_tdo.size()), 64'(0));
        check("enable_queue_drained", 64'(exp_en.size()), 64'(0));
        check("busy_queue_drained", 64'(exp_busy.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jtag_bist_dr.md
Name: jtag_bist_dr

Overview:
JTAG-side data-register bank that feeds the BIST test module and collects its result. It shifts configuration and user-test vectors in from TDI and presents them as stable parallel words (BIST_CONF_REG, BIST_USER_TEST). It runs the BIST for a programmed number of cycles via ENABLE, then latches BIST_STATUS_REG so it can be shifted out on TDO. It sits between the TAP controller/instruction register and the bist/fsm pair.

Parameters:
CONF_W, 13, width of BIST configuration word
USER_W, 2052, width of user test vector
STAT_W, 16, width of BIST status word
RUN_W, 16, width of run-cycle counter
IR_CONF, 4'h2, opcode selecting CONF DR
IR_USER, 4'h3, opcode selecting USER DR
IR_RUN, 4'h4, opcode selecting RUN DR
IR_STATUS, 4'h5, opcode selecting STATUS DR

Ports:
CLK  in  1  system/TCK-domain clock
RST  in  1  synchronous active-high reset
IR  in  4  current instruction from TAP
CAPTURE_DR  in  1  one-cycle strobe, TAP Capture-DR
SHIFT_DR  in  1  per-bit shift enable, TAP Shift-DR
UPDATE_DR  in  1  one-cycle strobe, TAP Update-DR
TDI  in  1  serial data in
TDO  out  1  serial data out
BIST_STATUS_REG  in  STAT_W  status from bist
BIST_CONF_REG  out  CONF_W  config shadow to bist
BIST_USER_TEST  out  USER_W  user-test shadow to bist
ENABLE  out  1  BIST run enable
BIST_BUSY  out  1  run in progress
BIST_DONE  out  1  result latched and valid

Behaviour:
- Single clock CLK; reset synchronous, active-high. On RST: all shift registers, shadows, counter, status hold = 0; ENABLE=0, BIST_BUSY=0, BIST_DONE=0, TDO=0; state IDLE.
- DR select by IR: CONF (CONF_W), USER (USER_W), RUN (RUN_W), STATUS (STAT_W+2); any other code selects 1-bit BYPASS.
- Strobe priority if several asserted in one cycle: CAPTURE_DR > SHIFT_DR > UPDATE_DR.
- Capture: CONF/USER load current shadow value; RUN loads remaining count; STATUS loads {BIST_BUSY, BIST_DONE, status_hold}, LSB = status_hold[0]; BYPASS loads 0.
- Shift: selected sr <= {TDI, sr[W-1:1]} (LSB first). TDO = sr[0] of selected register, a flop output with no combinational path from TDI.
- Update: CONF/USER shadow <= shift register, only when state IDLE or DONE; ignored while BUSY (shadows stay stable during a run). Shadow change is visible on outputs the cycle after UPDATE_DR.
- RUN update with value N:
  - IDLE/DONE and N!=0 -> RUN: counter=N, BIST_DONE<=0, BIST_BUSY<=1, ENABLE=1 from the next cycle for exactly N cycles.
  - IDLE/DONE and N=0 -> no effect.
  - RUN and N=0 -> abort: next cycle ENABLE=0, BUSY=0, state IDLE, DONE stays 0, status_hold unchanged.
  - RUN and N!=0 -> ignored.
- FSM IDLE -> RUN -> SETTLE -> DONE.
  - RUN: counter decrements each cycle; on the cycle counter==1 it goes to SETTLE, with ENABLE low from the next cycle.
  - SETTLE (1 cycle, ENABLE=0, BUSY=1): status_hold <= BIST_STATUS_REG.
  - DONE: BUSY=0, DONE=1. Holds until a new non-zero RUN update or RST.
- Counter range 1..2^RUN_W-1; no wrap (RUN exits at 1).
- RST mid-run: next cycle everything returns to reset values.

Test Plan:
- Reset: assert RST 2 cycles -> all outputs 0, TDO=0, capture STATUS shifts out 18 zeros.
- CONF load: IR=IR_CONF, shift 13'h1A5 LSB-first, UPDATE_DR -> BIST_CONF_REG=13'h1A5 next cycle. A re-capture and shift returns 13'h1A5 on TDO.
- Run: IR=IR_RUN, shift 16'd5, UPDATE_DR -> ENABLE high exactly 5 cycles starting the cycle after the update. BUSY high for 6 cycles. With BIST_STATUS_REG=16'hBEEF, DONE=1 and the STATUS capture/shift yields 16'hBEEF, then DONE=1, BUSY=0.
- Update lockout: during a 100-cycle run, update USER with all-ones -> BIST_USER_TEST unchanged. After DONE the same update takes effect.
- Abort: start run of 50, after 10 cycles update RUN with 0 -> ENABLE low next cycle, BUSY=0, DONE=0, status_hold keeps its previous value.
- Bypass/priority: IR=4'hF, shift pattern 1011 -> TDO delays it by one bit. CAPTURE_DR and UPDATE_DR together on CONF -> capture only, shadow unchanged.
